// File: rtl/univ_shift_register.sv
// Universal shift register: hold, shift left/right or parallel load each cycle,
// with a per-frame shift counter and a one-cycle done pulse every WIDTH shifts.
module univ_shift_register #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             si,
   input  logic [WIDTH-1:0] pi,
   output logic [WIDTH-1:0] po,
   output logic             so_msb,
   output logic             so_lsb,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             done
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_SHL   = 2'b01,
      MODE_SHR   = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] po_q, po_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift_c;

   // Next-state: data path selection and frame counting
   always_comb begin
      po_d    = po_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      shift_c = 1'b0;
      if (en) begin
         case (mode_e'(mode))
            MODE_SHL: begin
               po_d    = {po_q[WIDTH-2:0], si};
               shift_c = 1'b1;
            end
            MODE_SHR: begin
               po_d    = {si, po_q[WIDTH-1:1]};
               shift_c = 1'b1;
            end
            MODE_LOAD: begin
               po_d  = pi;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      // Both shift directions advance the same frame counter
      if (shift_c) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         po_q   <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         po_q   <= po_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign po      = po_q;
   assign bit_cnt = cnt_q;
   assign done    = done_q;
   assign so_msb  = po_q[WIDTH-1];
   assign so_lsb  = po_q[0];

endmodule

// File: tb/tb_univ_shift_register.sv
// Self-checking bench for univ_shift_register (WIDTH=8): directed test-plan
// scenarios followed by random traffic, all checked against an arithmetic model.
module tb_univ_shift_register;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W);

   logic          clk;
   logic          rst;
   logic          en;
   logic [1:0]    mode;
   logic          si;
   logic [W-1:0]  pi;
   logic [W-1:0]  po;
   logic          so_msb;
   logic          so_lsb;
   logic [CW-1:0] bit_cnt;
   logic          done;

   int checks   = 0;
   int failures = 0;

   // Reference model state: register value and shifts since frame start
   logic [W-1:0] m_po;
   int           m_shifts;
   logic         m_done;
   int           done_seen;

   univ_shift_register #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .si      (si),
      .pi      (pi),
      .po      (po),
      .so_msb  (so_msb),
      .so_lsb  (so_lsb),
      .bit_cnt (bit_cnt),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance model, check every output after the edge
   task automatic step(input logic r, input logic e, input logic [1:0] m,
                       input logic s, input logic [W-1:0] p);
      rst = r; en = e; mode = m; si = s; pi = p;
      @(posedge clk);
      m_done = 1'b0;
      if (r) begin
         m_po     = '0;
         m_shifts = 0;
      end else if (e) begin
         if (m == 2'd1 || m == 2'd2) begin
            if (m == 2'd1) m_po = W'(m_po * 2 + 32'(s));
            else           m_po = W'((m_po >> 1) | (W'(s) << (W - 1)));
            m_shifts++;
            if (m_shifts % W == 0) m_done = 1'b1;
         end else if (m == 2'd3) begin
            m_po     = p;
            m_shifts = 0;
         end
      end
      #1;
      if (done === 1'b1) done_seen++;
      chk("model_po",      64'(po),      64'(m_po));
      chk("model_so_msb",  64'(so_msb),  64'(m_po[W-1]));
      chk("model_so_lsb",  64'(so_lsb),  64'(m_po[0]));
      chk("model_bit_cnt", 64'(bit_cnt), 64'(m_shifts % W));
      chk("model_done",    64'(done),    64'(m_done));
   endtask

   initial begin
      logic [7:0]   piso_pat;
      logic [7:0]   sipo_si;
      logic [W-1:0] held;
      piso_pat  = 8'hA5;
      sipo_si   = 8'b0100_1011;
      m_po      = '0;
      m_shifts  = 0;
      m_done    = 1'b0;
      done_seen = 0;
      rst = 1'b1; en = 1'b0; mode = 2'b00; si = 1'b0; pi = '0;

      // Reset state
      step(1'b1, 1'b0, 2'b00, 1'b0, '0);
      chk("reset_po", 64'(po), 64'h0);
      chk("reset_done", 64'(done), 64'h0);

      // Reset priority over a simultaneous load
      step(1'b0, 1'b1, 2'b11, 1'b0, 8'hFF);
      chk("pre_prio_po", 64'(po), 64'hFF);
      step(1'b1, 1'b1, 2'b11, 1'b0, 8'h3C);
      chk("prio_po", 64'(po), 64'h00);
      chk("prio_bit_cnt", 64'(bit_cnt), 64'h0);
      chk("prio_done", 64'(done), 64'h0);

      // PISO MSB-first
      step(1'b0, 1'b1, 2'b11, 1'b0, 8'hA5);
      chk("piso_msb_0", 64'(so_msb), 64'(piso_pat[7]));
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 2'b01, 1'b0, '0);
         if (i <= 7) chk("piso_msb", 64'(so_msb), 64'(piso_pat[7-i]));
         if (i <= 7) chk("piso_no_done", 64'(done), 64'h0);
      end
      chk("piso_final_po", 64'(po), 64'h00);
      chk("piso_done", 64'(done), 64'h1);
      step(1'b0, 1'b1, 2'b00, 1'b0, '0);
      chk("piso_done_drop", 64'(done), 64'h0);

      // SIPO LSB-first
      step(1'b1, 1'b0, 2'b00, 1'b0, '0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'b10, sipo_si[i], '0);
      chk("sipo_po", 64'(po), 64'h4B);
      chk("sipo_done", 64'(done), 64'h1);

      // Enable low and mode hold freeze register and counter
      step(1'b1, 1'b0, 2'b00, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b01, 1'($urandom), '0);
      chk("hold_start_cnt", 64'(bit_cnt), 64'h3);
      held = m_po;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) step(1'b0, 1'b0, 2'b01, 1'($urandom), W'($urandom));
         else       step(1'b0, 1'b1, 2'b00, 1'($urandom), W'($urandom));
         chk("hold_po", 64'(po), 64'(held));
         chk("hold_cnt", 64'(bit_cnt), 64'h3);
         chk("hold_done", 64'(done), 64'h0);
      end

      // Load mid-frame restarts the frame
      for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'b10, 1'($urandom), '0);
      chk("mid_cnt5", 64'(bit_cnt), 64'h5);
      step(1'b0, 1'b1, 2'b11, 1'b0, 8'h81);
      chk("load_cnt", 64'(bit_cnt), 64'h0);
      chk("load_po", 64'(po), 64'h81);
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 2'b01, 1'($urandom), '0);
         chk("load_frame_done", 64'(done), (i == 8) ? 64'h1 : 64'h0);
      end

      // Reset coinciding with the frame-completing shift
      step(1'b1, 1'b0, 2'b00, 1'b0, '0);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2'b01, 1'($urandom), '0);
      chk("pre_rst_cnt", 64'(bit_cnt), 64'h7);
      step(1'b1, 1'b1, 2'b01, 1'b1, '0);
      chk("rst_end_done", 64'(done), 64'h0);
      chk("rst_end_cnt", 64'(bit_cnt), 64'h0);
      done_seen = 0;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 2'b01, 1'($urandom), '0);
      step(1'b0, 1'b1, 2'b00, 1'b0, '0);
      chk("rst_end_frame_dones", 64'(done_seen), 64'h1);

      // Back-to-back frames, mixed directions: pulses exactly W shifts apart
      done_seen = 0;
      for (int i = 1; i <= 24; i++) begin
         step(1'b0, 1'b1, ($urandom % 2) ? 2'b01 : 2'b10, 1'($urandom), '0);
         chk("stream_done", 64'(done), (i % 8 == 0) ? 64'h1 : 64'h0);
      end
      chk("stream_done_count", 64'(done_seen), 64'h3);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 32) == 0, ($urandom % 4) != 0, 2'($urandom),
              1'($urandom), W'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/univ_shift_register.md
# univ_shift_register

Parametrised universal shift register: one WIDTH-bit register that can hold, shift left, shift right or parallel-load, selected per cycle. It also keeps a shift counter and pulses a frame-done flag after every WIDTH shifts. It replaces the fixed 4-bit SISO/SIPO/PISO/PIPO variants as the single serialiser/deserialiser primitive for the datapath blocks.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), width of bit_cnt; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = every register holds.
- mode  input  2  operation: 00 hold, 01 shift left (MSB-first), 10 shift right (LSB-first), 11 parallel load.
- si  input  1  serial input bit.
- pi  input  WIDTH  parallel load data.
- po  output  WIDTH  register contents.
- so_msb  output  1  po[WIDTH-1]; serial output for shift-left use.
- so_lsb  output  1  po[0]; serial output for shift-right use.
- bit_cnt  output  CNT_W  number of shifts completed in the current frame, 0..WIDTH-1.
- done  output  1  one-cycle pulse when a frame of WIDTH shifts completes.

## Operation
- Reset (rst=1 at a clock edge): po=0, bit_cnt=0, done=0.
  - Reset has priority over en and mode.
  - so_msb and so_lsb therefore read 0.
- en=0: po and bit_cnt hold; done=0.
- en=1, mode=00 (hold): po and bit_cnt hold; done=0.
- en=1, mode=01 (shift left): po <= {po[WIDTH-2:0], si}.
- en=1, mode=10 (shift right): po <= {si, po[WIDTH-1:1]}.
- en=1, mode=11 (load):
  - po <= pi and bit_cnt <= 0; done=0.
  - A load always starts a new frame.
- Shift counting (mode 01 or 10 with en=1):
  - If bit_cnt < WIDTH-1: bit_cnt increments; done=0.
  - If bit_cnt == WIDTH-1: bit_cnt wraps to 0 and done=1 for the next cycle only.
  - Left and right shifts both count. A direction change mid-frame does not reset the counter.
- Frames need no load between them. A continuous shift stream yields done once every WIDTH shifts.
- done is 0 in every cycle that does not immediately follow a frame-completing shift.

## Timing
- po, bit_cnt and done are registered. so_msb and so_lsb are direct wires from po, with no added latency.
- Load to output: pi appears on po one cycle after the load edge.
  - so_msb = pi[WIDTH-1] and so_lsb = pi[0] in that same cycle.
- Serialisation: after a load, WIDTH consecutive shift cycles present all WIDTH bits on the serial output, one bit per cycle.
- Deserialisation: WIDTH consecutive shifts fully replace po. done rises in the same cycle the final word appears on po.
- done is high for exactly one cycle. Back-to-back frames produce done pulses exactly WIDTH cycles apart.
- Reset mid-frame: the partial frame is discarded and no done pulse is produced, even if the reset edge coincides with the WIDTH-th shift.
- No combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=8.
- Reset priority: with po=8'hFF, assert rst together with en=1, mode=11, pi=8'h3C -> next cycle po=8'h00, bit_cnt=0, done=0.
- PISO MSB-first: load 8'hA5, then 8 cycles of mode=01 with si=0 ->
  - so_msb reads 1,0,1,0,0,1,0,1 across the load cycle and the following 7 shifts.
  - After the 8th shift, po=8'h00 and done=1 for one cycle.
- SIPO LSB-first: from reset, 8 cycles of mode=10 with si = 1,1,0,1,0,0,1,0 -> po=8'h4B and done=1 in the cycle after the 8th shift.
- Enable/hold: mid-frame at bit_cnt=3, apply en=0 with mode=01 for 3 cycles, then en=1, mode=00 for 2 cycles -> po and bit_cnt unchanged; done stays 0.
- Load mid-frame: after 5 shifts, load 8'h81, then shift continuously -> bit_cnt=0 after the load; done occurs only after 8 further shifts, not after 3.
- Reset at frame end: after 7 shifts, assert rst in the cycle of the 8th shift -> done stays 0, bit_cnt=0; a following full frame gives exactly one done.
